alu_pipe: RTL



---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_pipe_if.sv | 31 +++
 rtl/alu_mul_iter.sv | 68 ++++++
 rtl/alu_pipe.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the handshaked ALU.
//   alu_op_e    - 4-bit opcode encoding; every other code is illegal.
//   alu_state_e - control FSM states.
//   FLAG_*      - bit positions of the status flags in the internal flag vector.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_SRA = 4'h8,
    OP_MUL = 4'h9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } alu_state_e;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_V    = 2;
  localparam int FLAG_N    = 3;
  localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand-issue and result-consumer handshakes of alu_pipe.
//   master - issuing/consuming side (drives operands and out_ready)
//   slave  - the ALU (drives in_ready, result and flags)
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             carry_flag;
  logic             overflow_flag;
  logic             negative_flag;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result,
           zero_flag, carry_flag, overflow_flag, negative_flag
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result,
           zero_flag, carry_flag, overflow_flag, negative_flag
  );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst  - clock, async active-high reset (aborts any product in flight)
//   start_i   - latch a_i/b_i and begin; ignored while a product is running
//   a_i, b_i  - WIDTH-bit operands
//   done_o    - high in the cycle of the final step (edge WIDTH after start)
//   prod_o    - 2*WIDTH product; valid while done_o is high and held afterwards
//               until the next start
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] step_sum;

  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    if (cnt_q == '0) begin
      if (start_i) begin
        mcand_d  = {{WIDTH{1'b0}}, a_i};
        mplier_d = b_i;
        acc_d    = '0;
        cnt_d    = CW'(WIDTH);
      end
    end else begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

  // The final sum is exposed combinationally so the consumer can load it on
  // the same edge as the last step.
  assign done_o = (cnt_q == CW'(1));
  assign prod_o = done_o ? step_sum : acc_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result and Z/C/V/N flags.
//   clk, rst - clock, async active-high reset
//   bus      - alu_pipe_if.slave: in_valid/in_ready, a, b, opcode,
//              out_valid/out_ready, result, zero/carry/overflow/negative flags
// Single-cycle ops load the output register on the accept edge. MUL hands off
// to alu_mul_iter and blocks new input until its product is loaded.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   res_q,   res_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic               out_valid_q, out_valid_d;

  alu_op_e            op;
  logic               out_free, accept;
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  // ---- single-cycle datapath ----
  logic [WIDTH:0]     sum, diff, shl_w, shr_w, sra_w;
  logic [SW-1:0]      sh;
  logic               big_sh;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  assign op     = alu_op_e'(bus.opcode);
  assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff   = {1'b0, bus.a} - {1'b0, bus.b};
  // The whole of b is the shift amount; once it is known to be < WIDTH only
  // the low bits matter.
  assign big_sh = (33'(bus.b) >= 33'(WIDTH));
  assign sh     = bus.b[SW-1:0];
  // One guard bit on the shifted-out side captures the last bit lost.
  assign shl_w  = {1'b0, bus.a} << sh;
  assign shr_w  = {bus.a, 1'b0} >> sh;
  assign sra_w  = $signed({bus.a, 1'b0}) >>> sh;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_NOT: alu_res = ~bus.a;
      OP_SHL: if (!big_sh) begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: if (!big_sh) begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      OP_SRA: begin
        if (big_sh) alu_res = {WIDTH{bus.a[WIDTH-1]}};
        else begin
          alu_res = sra_w[WIDTH:1];
          alu_c   = sra_w[0];
        end
      end
      default: ;  // MUL goes through the iterator; illegal codes return 0
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // ---- control ----
  assign out_free     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (state_q == ST_IDLE) && out_free && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  logic             load, load_mul;
  logic [WIDTH-1:0] load_res;
  logic             load_c, load_v;

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    load      = 1'b0;
    load_mul  = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (op == OP_MUL) begin
          mul_start = 1'b1;
          state_d   = ST_MUL;
        end else begin
          load = 1'b1;
        end
      end
      ST_MUL: if (mul_done) begin
        if (out_free) begin
          load     = 1'b1;
          load_mul = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: if (out_free) begin
        load     = 1'b1;
        load_mul = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_res = load_mul ? mul_prod[WIDTH-1:0] : alu_res;
    load_c   = load_mul ? |mul_prod[2*WIDTH-1:WIDTH] : alu_c;
    load_v   = load_mul ? 1'b0 : alu_v;

    res_d       = res_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    if (load) begin
      res_d           = load_res;
      flags_d[FLAG_Z] = (load_res == '0);
      flags_d[FLAG_C] = load_c;
      flags_d[FLAG_V] = load_v;
      flags_d[FLAG_N] = load_res[WIDTH-1];
      out_valid_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      res_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.result        = res_q;
  assign bus.zero_flag     = flags_q[FLAG_Z];
  assign bus.carry_flag    = flags_q[FLAG_C];
  assign bus.overflow_flag = flags_q[FLAG_V];
  assign bus.negative_flag = flags_q[FLAG_N];

endmodule
